// File: rtl/reg8_rd_ctrl_if.sv
// ---------------------------------------------------------------------------
// reg8_rd_ctrl_if
//
// Purpose:
//   Groups the write-request handshake, the eight register-bank read ports
//   and the valid/ready output stream that sit around reg8_rd_ctrl.
//
// Signals:
//   wr_req        producer asks to write the shared bank input this cycle
//   wr_acc        controller accepted that write (combinational)
//   wr_en[7:0]    one-hot write enable into the register bank
//   d_in0..d_in7  current contents of the eight bank entries
//   m_data        registered head-of-FIFO data
//   m_valid       m_data holds an unconsumed entry
//   m_ready       consumer takes m_data when m_valid && m_ready
//
// Modports:
//   master  the controller's view (drives wr_acc, wr_en, m_data, m_valid)
//   slave   the surrounding bank/producer/consumer view
// ---------------------------------------------------------------------------
interface reg8_rd_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              wr_req;
    logic              wr_acc;
    logic [7:0]        wr_en;
    logic [DATA_W-1:0] d_in0;
    logic [DATA_W-1:0] d_in1;
    logic [DATA_W-1:0] d_in2;
    logic [DATA_W-1:0] d_in3;
    logic [DATA_W-1:0] d_in4;
    logic [DATA_W-1:0] d_in5;
    logic [DATA_W-1:0] d_in6;
    logic [DATA_W-1:0] d_in7;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        input  wr_req,
        input  d_in0, d_in1, d_in2, d_in3, d_in4, d_in5, d_in6, d_in7,
        input  m_ready,
        output wr_acc,
        output wr_en,
        output m_data,
        output m_valid
    );

    modport slave (
        output wr_req,
        output d_in0, d_in1, d_in2, d_in3, d_in4, d_in5, d_in6, d_in7,
        output m_ready,
        input  wr_acc,
        input  wr_en,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/reg8_rd_ctrl.sv
// ---------------------------------------------------------------------------
// reg8_rd_ctrl
//
// Purpose:
//   Pointer/occupancy controller for an external 8 x DATA_W register bank
//   used as FIFO storage. Accepts writes into the bank through one-hot write
//   enables, and moves the oldest bank entry into a registered valid/ready
//   output stage whenever that stage is empty or being consumed. Total
//   capacity is nine words: eight in the bank plus one in the output stage.
//
// Ports:
//   clk           single clock, rising edge
//   reset         synchronous, active-high
//   bus           reg8_rd_ctrl_if.master (wr_req/wr_acc/wr_en, d_in0..7,
//                 m_data/m_valid/m_ready)
//   count[3:0]    entries still in the bank (not yet moved to m_data), 0..8
//   full          count == 8
//   empty         count == 0
//   ovf           sticky: a write request was refused; cleared by reset only
//   almost_full   (optional) count >= 7, forced 0 during reset
//   almost_empty  (optional) count <= 1, forced 0 during reset
//
// Configuration:
//   Define REG8_RD_ALMOST_FLAGS_EN to add the almost_full / almost_empty
//   outputs. Without it those ports are absent and nothing else changes.
// ---------------------------------------------------------------------------
module reg8_rd_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic           clk,
    input  logic           reset,
    reg8_rd_ctrl_if.master bus,
    output logic [3:0]     count,
    output logic           full,
    output logic           empty,
    output logic           ovf
`ifdef REG8_RD_ALMOST_FLAGS_EN
    ,
    output logic           almost_full,
    output logic           almost_empty
`endif
);

    localparam logic [3:0] COUNT_MAX = 4'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [3:0]        count_q;
    logic [3:0]        count_next;
    logic              m_valid_q;
    logic [DATA_W-1:0] m_data_q;
    logic              ovf_q;

    logic [DATA_W-1:0] bank_out [DEPTH];
    logic              load;
    logic              wr_acc;
    logic              wr_refused;
    logic [DEPTH-1:0]  wr_en;

    // Bank outputs gathered into an array so the read side is a plain mux.
    assign bank_out[0] = bus.d_in0;
    assign bank_out[1] = bus.d_in1;
    assign bank_out[2] = bus.d_in2;
    assign bank_out[3] = bus.d_in3;
    assign bank_out[4] = bus.d_in4;
    assign bank_out[5] = bus.d_in5;
    assign bank_out[6] = bus.d_in6;
    assign bank_out[7] = bus.d_in7;

    // A load moves the oldest bank entry into the output register whenever
    // there is something in the bank and the output slot is free or being
    // consumed this cycle.
    always_comb begin
        load = (count_q != 4'd0) && (!m_valid_q || bus.m_ready);
    end

    // A write while the bank is full is still accepted when a load frees an
    // entry in the same cycle; the load reads the old word before the edge,
    // so the write can safely reuse that slot.
    always_comb begin
        wr_acc     = bus.wr_req && !reset && ((count_q < COUNT_MAX) || load);
        wr_refused = bus.wr_req && !reset && !wr_acc;
    end

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_acc && (wr_ptr == PTR_W'(i))) begin
                wr_en[i] = 1'b1;
            end
        end
    end

    always_comb begin
        count_next = count_q;
        unique case ({wr_acc, load})
            2'b10:   count_next = count_q + 4'd1;
            2'b01:   count_next = count_q - 4'd1;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= 4'd0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_next;
        end
    end

    // Output stage: a load always wins over a plain consume, which keeps the
    // stream at one word per cycle while the bank has data.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else if (load) begin
            m_valid_q <= 1'b1;
            m_data_q  <= bank_out[rd_ptr];
        end else if (m_valid_q && bus.m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (wr_refused) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.wr_acc  = wr_acc;
    assign bus.wr_en   = wr_en;
    assign bus.m_data  = m_data_q;
    assign bus.m_valid = m_valid_q;

    assign count = count_q;
    assign full  = (count_q == COUNT_MAX);
    assign empty = (count_q == 4'd0);
    assign ovf   = ovf_q;

`ifdef REG8_RD_ALMOST_FLAGS_EN
    // Both flags are held low while reset is asserted, even though the
    // count register only clears at the next edge.
    assign almost_full  = !reset && (count_q >= (COUNT_MAX - 4'd1));
    assign almost_empty = !reset && (count_q <= 4'd1);
`endif

endmodule

// File: tb/tb_reg8_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg8_rd_ctrl
//
// Purpose:
//   Self-checking bench for reg8_rd_ctrl. Provides the 8-entry register bank
//   around the controller, a queue-based reference model of the FIFO, a
//   table of hand-computed vectors, directed corner-case sequences and a
//   randomized run.
// ---------------------------------------------------------------------------
module tb_reg8_rd_ctrl;

    localparam int DATA_W = 32;

    typedef struct {
        bit          rst;
        bit          req;
        logic [31:0] data;
        bit          rdy;
        bit          exp_acc;
        logic [7:0]  exp_wr_en;
        logic [3:0]  exp_count;
        bit          exp_mvalid;
        logic [31:0] exp_mdata;
        bit          exp_ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        ovf;
`ifdef REG8_RD_ALMOST_FLAGS_EN
    logic        almost_full;
    logic        almost_empty;
`endif

    logic [31:0] wdata;
    logic [31:0] bank [8];

    int total = 0;
    int bad   = 0;

    // Reference model state: the bank as an ordered queue, plus the output
    // slot, the sticky overflow flag and the number of accepted writes.
    logic [31:0] mq [$];
    bit          m_ov_valid;
    logic [31:0] m_ov_data;
    bit          m_ovf;
    int unsigned m_nwr;

    reg8_rd_ctrl_if #(.DATA_W(DATA_W)) bus ();

    reg8_rd_ctrl #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .count        (count),
        .full         (full),
        .empty        (empty),
`ifdef REG8_RD_ALMOST_FLAGS_EN
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`endif
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    // Register bank: every entry captures the shared write data on its enable.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (bus.wr_en[i]) bank[i] <= wdata;
        end
    end

    assign bus.d_in0 = bank[0];
    assign bus.d_in1 = bank[1];
    assign bus.d_in2 = bank[2];
    assign bus.d_in3 = bank[3];
    assign bus.d_in4 = bank[4];
    assign bus.d_in5 = bank[5];
    assign bus.d_in6 = bank[6];
    assign bus.d_in7 = bank[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t model_expect(bit rst, bit req, logic [31:0] d, bit rdy);
        vec_t e;
        bit   ld;
        ld           = (mq.size() > 0) && (!m_ov_valid || rdy);
        e.rst        = rst;
        e.req        = req;
        e.data       = d;
        e.rdy        = rdy;
        e.exp_acc    = req && !rst && ((mq.size() < 8) || ld);
        e.exp_wr_en  = e.exp_acc ? 8'(1 << (m_nwr % 8)) : 8'h00;
        e.exp_count  = 4'(mq.size());
        e.exp_mvalid = m_ov_valid;
        e.exp_mdata  = m_ov_data;
        e.exp_ovf    = m_ovf;
        return e;
    endfunction

    task automatic model_update(input bit rst, input bit req, input logic [31:0] d, input bit rdy);
        vec_t me;
        bit   ld;
        me = model_expect(rst, req, d, rdy);
        ld = (mq.size() > 0) && (!m_ov_valid || rdy);
        if (rst) begin
            mq.delete();
            m_ov_valid = 1'b0;
            m_ov_data  = '0;
            m_ovf      = 1'b0;
            m_nwr      = 0;
        end else begin
            if (ld) begin
                m_ov_data  = mq.pop_front();
                m_ov_valid = 1'b1;
            end else if (m_ov_valid && rdy) begin
                m_ov_valid = 1'b0;
            end
            if (me.exp_acc) begin
                mq.push_back(d);
                m_nwr++;
            end else if (req) begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input vec_t e, input string tag);
        chk({tag, ".wr_acc"},  32'(bus.wr_acc),  32'(e.exp_acc));
        chk({tag, ".wr_en"},   32'(bus.wr_en),   32'(e.exp_wr_en));
        chk({tag, ".count"},   32'(count),       32'(e.exp_count));
        chk({tag, ".full"},    32'(full),        32'(e.exp_count == 4'd8));
        chk({tag, ".empty"},   32'(empty),       32'(e.exp_count == 4'd0));
        chk({tag, ".m_valid"}, 32'(bus.m_valid), 32'(e.exp_mvalid));
        chk({tag, ".m_data"},  bus.m_data,       e.exp_mdata);
        chk({tag, ".ovf"},     32'(ovf),         32'(e.exp_ovf));
`ifdef REG8_RD_ALMOST_FLAGS_EN
        chk({tag, ".almost_full"},  32'(almost_full),  32'(!e.rst && (e.exp_count >= 4'd7)));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(!e.rst && (e.exp_count <= 4'd1)));
`endif
    endtask

    // One clock cycle: drive at the falling edge, compare 1 time unit later,
    // then let the rising edge happen and advance the model.
    task automatic applyStimulus(input bit rst, input bit req, input logic [31:0] d,
                                 input bit rdy, input bit use_tab, input vec_t tab,
                                 input string tag);
        vec_t e;
        @(negedge clk);
        reset       = rst;
        bus.wr_req  = req;
        wdata       = d;
        bus.m_ready = rdy;
        e = use_tab ? tab : model_expect(rst, req, d, rdy);
        #1;
        checkOutput(e, tag);
        @(posedge clk);
        model_update(rst, req, d, rdy);
    endtask

    task automatic cyc(input bit rst, input bit req, input logic [31:0] d, input bit rdy,
                       input string tag);
        vec_t dummy;
        dummy = '{default: 0};
        applyStimulus(rst, req, d, rdy, 1'b0, dummy, tag);
    endtask

    task automatic settle();
        #2;
    endtask

    vec_t vecs [12];

    initial begin
        reset       = 1'b1;
        bus.wr_req  = 1'b0;
        bus.m_ready = 1'b0;
        wdata       = '0;

        //        rst req data          rdy acc wr_en cnt mv mdata         ovf
        vecs[0]  = '{1, 1, 32'h0,         0, 0, 8'h00, 0, 0, 32'h0,         0};
        vecs[1]  = '{1, 1, 32'h0,         0, 0, 8'h00, 0, 0, 32'h0,         0};
        vecs[2]  = '{0, 1, 32'hA5A5_0001, 0, 1, 8'h01, 0, 0, 32'h0,         0};
        vecs[3]  = '{0, 0, 32'h0,         0, 0, 8'h00, 1, 0, 32'h0,         0};
        vecs[4]  = '{0, 0, 32'h0,         0, 0, 8'h00, 0, 1, 32'hA5A5_0001, 0};
        vecs[5]  = '{0, 0, 32'h0,         1, 0, 8'h00, 0, 1, 32'hA5A5_0001, 0};
        vecs[6]  = '{0, 0, 32'h0,         0, 0, 8'h00, 0, 0, 32'hA5A5_0001, 0};
        vecs[7]  = '{0, 1, 32'h0000_0022, 0, 1, 8'h02, 0, 0, 32'hA5A5_0001, 0};
        vecs[8]  = '{0, 0, 32'h0,         0, 0, 8'h00, 1, 0, 32'hA5A5_0001, 0};
        vecs[9]  = '{0, 0, 32'h0,         0, 0, 8'h00, 0, 1, 32'h0000_0022, 0};
        vecs[10] = '{1, 1, 32'h0,         0, 0, 8'h00, 0, 1, 32'h0000_0022, 0};
        vecs[11] = '{0, 0, 32'h0,         0, 0, 8'h00, 0, 0, 32'h0,         0};

        // Unchecked cycle so the DUT leaves its power-up state.
        @(negedge clk);
        @(posedge clk);
        model_update(1'b1, 1'b0, '0, 1'b0);

        $display("[TB] table vectors");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].data, vecs[i].rdy,
                          1'b1, vecs[i], $sformatf("vec%0d", i));
        end

        $display("[TB] fill with m_ready=0 then drain");
        cyc(1, 0, 0, 0, "fill_rst");
        for (int i = 1; i <= 10; i++) cyc(0, 1, 32'(i), 0, $sformatf("fill%0d", i));
        settle();
        chk("fill.full",   32'(full),       32'd1);
        chk("fill.ovf",    32'(ovf),        32'd1);
        chk("fill.count",  32'(count),      32'd8);
        chk("fill.m_data", bus.m_data,      32'd1);
        for (int j = 0; j < 9; j++) begin
            cyc(0, 0, 0, 1, $sformatf("drain%0d", j));
            settle();
            if (j < 8) begin
                chk($sformatf("drain%0d.m_data", j), bus.m_data, 32'(j + 2));
            end else begin
                chk("drain.m_valid_end", 32'(bus.m_valid), 32'd0);
                chk("drain.empty_end",   32'(empty),       32'd1);
            end
        end

        $display("[TB] full with simultaneous read and write");
        cyc(1, 0, 0, 0, "sim_rst");
        for (int i = 0; i < 9; i++) cyc(0, 1, 32'(200 + i), 0, $sformatf("sim_fill%0d", i));
        settle();
        chk("sim.count_full", 32'(count), 32'd8);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 32'(300 + i), 1, $sformatf("sim_rw%0d", i));
            settle();
            chk($sformatf("sim_rw%0d.count", i), 32'(count), 32'd8);
        end
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, $sformatf("sim_drain%0d", i));

        $display("[TB] reset mid-stream");
        cyc(1, 0, 0, 0, "mid_rst0");
        for (int i = 0; i < 6; i++) cyc(0, 1, 32'(50 + i), 0, $sformatf("mid_fill%0d", i));
        settle();
        chk("mid.count5",  32'(count),       32'd5);
        chk("mid.m_valid", 32'(bus.m_valid), 32'd1);
        cyc(1, 0, 0, 0, "mid_rst1");
        settle();
        chk("mid.count_clr",  32'(count),       32'd0);
        chk("mid.mvalid_clr", 32'(bus.m_valid), 32'd0);
        chk("mid.mdata_clr",  bus.m_data,       32'd0);
        cyc(0, 1, 32'h0000_00FF, 0, "mid_wr");
        cyc(0, 0, 0, 0, "mid_idle");
        settle();
        chk("mid.m_data_ff", bus.m_data,       32'h0000_00FF);
        chk("mid.m_valid_ff", 32'(bus.m_valid), 32'd1);
        chk("mid.count_ff",  32'(count),       32'd0);

        $display("[TB] randomized run");
        cyc(1, 0, 0, 0, "rnd_rst");
        for (int i = 0; i < 600; i++) begin
            bit r, q, m;
            r = ($urandom_range(0, 99) == 0);
            q = ($urandom_range(0, 3) != 0);
            if (i < 300) m = ($urandom_range(0, 9) < 3);
            else         m = ($urandom_range(0, 9) < 8);
            cyc(r, q, $urandom, m, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
